mode_ctrl: RTL
==============

# mode_ctrl

Sequencing controller for the TGIF datapath `mode_top`, driving its other end. It accepts block-level commands (key, nonce, AD, encrypt, decrypt, tag) and moves 32-bit words over valid/ready handshakes on pdi, sdi and pdo. It generates every control strobe `mode_top` consumes: state and tweakey shift/round enables, round init, load select, domain bytes, decrypt byte mask and counter correction. It sits between the LWC API front end and `mode_top`, one instance per core.

## Interface
- BUSWIDTH, 32, datapath word width; only 32 is supported.
- BUSWIDTHBYTE, 4, bytes per word.
- ROUNDS, 18, round-update cycles per block permutation.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  controller idle, command taken on valid&ready.
- cmd_op  in  3  0 KEY, 1 NONCE, 2 AD, 3 ENC, 4 DEC, 5 TAG; 6 and 7 are ignored (accepted, no action).
- cmd_last  in  1  last block of its type; sets domain bit0.
- cmd_bytes  in  5  valid bytes in block, 1..16; 0 means 16.
- sdi_valid / sdi_ready  in / out  1  key word handshake.
- pdi_valid / pdi_ready  in / out  1  public data word handshake.
- pdo_valid / pdo_ready  out / in  1  output word handshake.
- srst, sse, senc  out  1  state clear, state word-shift, state round enable.
- xrst, xse, xenc  out  1  tweakey clear, shift, round enable.
- erst  out  1  round-function init.
- sl  out  1  tweakey load select: 1 = loop pdo, 0 = sdi.
- correct_cnt  out  1  one-cycle counter correction.
- dold, dnew  out  8  previous and new domain bytes for the doubling unit.
- decrypt  out  BUSWIDTHBYTE  per-byte decrypt mask for the current word.

## Operation
- States: IDLE, KEY, LOAD, ABS, MSG, INIT, RND, FIX, TAG.
- IDLE: cmd_ready=1. On accept:
  - KEY → KEY.
  - NONCE → LOAD, with srst pulsed the accept cycle.
  - AD → ABS.
  - ENC/DEC → MSG.
  - TAG → TAG.
- Every 128-bit block is exactly 4 word beats; a 2-bit beat counter counts fires only.
- KEY: sdi_ready=1. Each fire asserts xse=1 with sl=0. After beat 3, return to IDLE. xrst is pulsed on the accept cycle.
- LOAD/ABS: pdi_ready=1. Each fire asserts sse=1. After beat 3 → INIT.
- MSG: fire = pdi_valid & pdo_ready.
  - pdi_ready=pdo_ready and pdo_valid=pdi_valid.
  - sse=fire.
  - decrypt byte i of beat b = (op==DEC) & (4b+i < bytes); 0 for ENC.
  - After beat 3 → INIT.
- INIT: erst=1 for one cycle → RND.
- RND: senc=xenc=1 for exactly ROUNDS cycles; no handshake ready is asserted → FIX.
- FIX: correct_cnt=1 for one cycle, then dold←dnew, then IDLE.
- dnew is latched at command accept as DOM[op] | cmd_last. dold holds the previous block's domain and is 0 after reset.
- TAG: pdo_valid=1; pdi_ready=sdi_ready=0. Each fire asserts sse=1 and sl=1. After beat 3 → IDLE, with no rounds run.

## Timing
- Reset (rst=0 at a clock edge):
  - Next state is IDLE.
  - All strobes, pdi_ready, sdi_ready, pdo_valid and decrypt are 0.
  - dold=dnew=0 and counters are 0.
  - cmd_ready=1 from the first cycle after rst returns high.
- Reset mid-RND or mid-MSG aborts immediately; partially transferred words are discarded with no further strobes.
- Strobes are combinational from state and handshake inputs, gated by fire. No strobe asserts while a handshake stalls.
- Latency for AD/NONCE/ENC/DEC, last beat fire to IDLE: 1 (INIT) + ROUNDS (RND) + 1 (FIX) cycles. The next cmd_ready=1 arrives ROUNDS+2 cycles after the last fire.
- Minimum block period at full throughput: ROUNDS+7 cycles (accept + 4 beats + INIT + ROUNDS + FIX).
- cmd_valid while busy has no effect; the command is held by the source.
- Simultaneous cmd_valid and rst=0: reset wins and the command is not accepted.
- Beat counter wraps 3→0 only on fire and never increments on stall.

## Structure
- Shared package `tgif_ctrl_pkg`:
  - state encoding;
  - op codes;
  - domain constants DOM_AD=8'h02, DOM_MSG=8'h04, DOM_TAG=8'h08, DOM_NONCE=8'h00;
  - round-counter width $clog2(ROUNDS+1).
- One sub-module `byte_mask_gen`: (beat, bytes, dec) → decrypt[3:0], combinational.
- Everything else stays in mode_ctrl.

## Test plan
- Key load: KEY, then 4 sdi words 0x00112233.. with sdi_valid gapped every other cycle → exactly 4 xse pulses, sl=0, xrst one pulse, back to IDLE.
- Nonce with ROUNDS=18: 4 back-to-back pdi fires → erst 1 cycle, then senc=xenc=1 for 18 cycles, correct_cnt 1 cycle; cmd_ready returns 20 cycles after the last fire.
- ENC with pdo_ready low for 3 cycles during beat 2 → no sse and pdi_ready=0 during the stall, decrypt=0, exactly 4 sse total.
- DEC with bytes=6, last=1 → decrypt per beat 4'b1111, 4'b0011, 4'b0000, 4'b0000; dnew=8'h05 and dold=8'h04 after a prior MSG block.
- rst low on round 9 of RND → next cycle all outputs 0, cmd_ready=1 after release, no correct_cnt.
- TAG after AD → 4 pdo beats with sl=1 and sse per fire, no erst/senc, IDLE after beat 3.

Source files
------------

// File: rtl/tgif_ctrl_pkg.sv
// rtl/tgif_ctrl_pkg.sv - shared types and constants for the TGIF mode controller
package tgif_ctrl_pkg;

  localparam int BUSWIDTH_DEF     = 32;
  localparam int BUSWIDTHBYTE_DEF = 4;
  localparam int ROUNDS_DEF       = 18;

  // Width of a counter that can hold 0..rounds
  function automatic int rnd_cnt_w(input int rounds);
    return $clog2(rounds + 1);
  endfunction

  localparam int RND_CNT_W = $clog2(ROUNDS_DEF + 1);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_KEY,
    ST_LOAD,
    ST_ABS,
    ST_MSG,
    ST_INIT,
    ST_RND,
    ST_FIX,
    ST_TAG
  } state_e;

  typedef enum logic [2:0] {
    OP_KEY   = 3'd0,
    OP_NONCE = 3'd1,
    OP_AD    = 3'd2,
    OP_ENC   = 3'd3,
    OP_DEC   = 3'd4,
    OP_TAG   = 3'd5,
    OP_RSV6  = 3'd6,
    OP_RSV7  = 3'd7
  } op_e;

  localparam logic [7:0] DOM_NONCE = 8'h00;
  localparam logic [7:0] DOM_AD    = 8'h02;
  localparam logic [7:0] DOM_MSG   = 8'h04;
  localparam logic [7:0] DOM_TAG   = 8'h08;

  // Base domain byte for a block type; bit0 (last) is OR-ed in by the caller
  function automatic logic [7:0] dom_of(input op_e op);
    case (op)
      OP_AD:          return DOM_AD;
      OP_ENC, OP_DEC: return DOM_MSG;
      OP_TAG:         return DOM_TAG;
      default:        return DOM_NONCE;
    endcase
  endfunction

endpackage

// File: rtl/byte_mask_gen.sv
// rtl/byte_mask_gen.sv - per-byte decrypt mask for one word of a block
module byte_mask_gen #(
  parameter int NB = 4
) (
  input  logic [1:0]    beat,
  input  logic [4:0]    bytes,
  input  logic          dec,
  output logic [NB-1:0] mask
);

  logic [5:0] nbytes;
  logic [5:0] base;

  // Byte i of this beat is decrypted when its block offset lies below the valid byte count
  always_comb begin
    mask   = '0;
    nbytes = (bytes == 5'd0) ? 6'd16 : {1'b0, bytes};
    base   = 6'(beat) * 6'(NB);
    for (int i = 0; i < NB; i++) begin
      mask[i] = dec && ((base + 6'(i)) < nbytes);
    end
  end

endmodule

// File: rtl/mode_ctrl.sv
// rtl/mode_ctrl.sv - block sequencing controller driving the mode_top datapath
module mode_ctrl
  import tgif_ctrl_pkg::*;
#(
  parameter int BUSWIDTH     = BUSWIDTH_DEF,
  parameter int BUSWIDTHBYTE = BUSWIDTHBYTE_DEF,
  parameter int ROUNDS       = ROUNDS_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [2:0]              cmd_op,
  input  logic                    cmd_last,
  input  logic [4:0]              cmd_bytes,
  input  logic                    sdi_valid,
  output logic                    sdi_ready,
  input  logic                    pdi_valid,
  output logic                    pdi_ready,
  output logic                    pdo_valid,
  input  logic                    pdo_ready,
  output logic                    srst,
  output logic                    sse,
  output logic                    senc,
  output logic                    xrst,
  output logic                    xse,
  output logic                    xenc,
  output logic                    erst,
  output logic                    sl,
  output logic                    correct_cnt,
  output logic [7:0]              dold,
  output logic [7:0]              dnew,
  output logic [BUSWIDTHBYTE-1:0] decrypt
);

  localparam int RW = rnd_cnt_w(ROUNDS);

  state_e                  state_q, state_d;
  op_e                     op_q, op_d;
  logic [1:0]              beat_q, beat_d;
  logic [RW-1:0]           rnd_q, rnd_d;
  logic [4:0]              bytes_q, bytes_d;
  logic [7:0]              dnew_q, dnew_d;
  logic [7:0]              dold_q, dold_d;
  logic                    fire;
  logic [BUSWIDTHBYTE-1:0] mask;

  byte_mask_gen #(.NB(BUSWIDTH / 8)) u_mask (
    .beat  (beat_q),
    .bytes (bytes_q),
    .dec   (op_q == OP_DEC),
    .mask  (mask)
  );

  assign dold = dold_q;
  assign dnew = dnew_q;

  // Next state, beat/round counters and all strobes; everything is held low while rst is asserted
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    beat_d      = beat_q;
    rnd_d       = rnd_q;
    bytes_d     = bytes_q;
    dnew_d      = dnew_q;
    dold_d      = dold_q;
    fire        = 1'b0;
    cmd_ready   = 1'b0;
    sdi_ready   = 1'b0;
    pdi_ready   = 1'b0;
    pdo_valid   = 1'b0;
    srst        = 1'b0;
    sse         = 1'b0;
    senc        = 1'b0;
    xrst        = 1'b0;
    xse         = 1'b0;
    xenc        = 1'b0;
    erst        = 1'b0;
    sl          = 1'b0;
    correct_cnt = 1'b0;
    decrypt     = '0;

    if (rst) begin
      case (state_q)
        ST_IDLE: begin
          cmd_ready = 1'b1;
          if (cmd_valid) begin
            beat_d  = 2'd0;
            bytes_d = cmd_bytes;
            op_d    = op_e'(cmd_op);
            case (op_e'(cmd_op))
              OP_KEY: begin
                xrst    = 1'b1;
                state_d = ST_KEY;
              end
              OP_NONCE: begin
                srst    = 1'b1;
                state_d = ST_LOAD;
              end
              OP_AD:          state_d = ST_ABS;
              OP_ENC, OP_DEC: state_d = ST_MSG;
              OP_TAG:         state_d = ST_TAG;
              default:        state_d = ST_IDLE;
            endcase
            // Reserved opcodes leave the domain register untouched
            if (cmd_op <= 3'd5) begin
              dnew_d = dom_of(op_e'(cmd_op)) | {7'd0, cmd_last};
            end
          end
        end
        ST_KEY: begin
          sdi_ready = 1'b1;
          fire      = sdi_valid;
          xse       = fire;
        end
        ST_LOAD, ST_ABS: begin
          pdi_ready = 1'b1;
          fire      = pdi_valid;
          sse       = fire;
        end
        ST_MSG: begin
          // Input and output words move together, so each side sees the other's handshake
          pdi_ready = pdo_ready;
          pdo_valid = pdi_valid;
          fire      = pdi_valid & pdo_ready;
          sse       = fire;
          decrypt   = mask;
        end
        ST_TAG: begin
          pdo_valid = 1'b1;
          fire      = pdo_ready;
          sse       = fire;
          sl        = fire;
        end
        ST_INIT: begin
          erst    = 1'b1;
          rnd_d   = '0;
          state_d = ST_RND;
        end
        ST_RND: begin
          senc  = 1'b1;
          xenc  = 1'b1;
          rnd_d = rnd_q + RW'(1);
          if (rnd_q == RW'(ROUNDS - 1)) begin
            state_d = ST_FIX;
          end
        end
        ST_FIX: begin
          correct_cnt = 1'b1;
          dold_d      = dnew_q;
          state_d     = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase

      // Four beats per block; key and tag blocks skip the permutation
      if (fire) begin
        beat_d = beat_q + 2'd1;
        if (beat_q == 2'd3) begin
          state_d = ((state_q == ST_KEY) || (state_q == ST_TAG)) ? ST_IDLE : ST_INIT;
        end
      end
    end
  end

  // State and datapath-control registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_KEY;
      beat_q  <= '0;
      rnd_q   <= '0;
      bytes_q <= '0;
      dnew_q  <= '0;
      dold_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      beat_q  <= beat_d;
      rnd_q   <= rnd_d;
      bytes_q <= bytes_d;
      dnew_q  <= dnew_d;
      dold_q  <= dold_d;
    end
  end

endmodule
